regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 99 +++++++++
 tb/tb_regfile_sb.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: register file with per-register busy scoreboard.
// Self-initialises after reset; reads bypass a same-cycle writeback.
module regfile_sb #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int INIT_MODE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  output logic              ready
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] regs_q [DEPTH];

  logic              run;
  logic              wr_ok;
  logic              hit_a, hit_b;
  logic [DATA_W-1:0] init_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (&cnt_q) state_d = S_RUN;
      end
      S_RUN: state_d = S_RUN;
    endcase
  end

  always_comb begin
    ready = (state_q == S_RUN);
  end

  assign run   = ready;
  assign wr_ok = run && wr_en && (wr_addr != '0);

  assign init_val = (INIT_MODE == 1) ? DATA_W'(cnt_q) : '0;

  // Reserve is applied after the clear so a newer producer wins.
  always_comb begin
    busy_d = busy_q;
    if (run) begin
      if (wr_en)  busy_d[wr_addr]  = 1'b0;
      if (rsv_en) busy_d[rsv_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!run)
      regs_q[cnt_q] <= init_val;
    else if (wr_ok)
      regs_q[wr_addr] <= wr_data;
  end

  assign hit_a = wr_en && (wr_addr == rd_addr_a);
  assign hit_b = wr_en && (wr_addr == rd_addr_b);

  assign rd_data_a = (!run || rd_addr_a == '0) ? '0 :
                     hit_a ? wr_data : regs_q[rd_addr_a];
  assign rd_data_b = (!run || rd_addr_b == '0) ? '0 :
                     hit_b ? wr_data : regs_q[rd_addr_b];

  assign rd_busy_a = run && !hit_a && busy_q[rd_addr_a];
  assign rd_busy_b = run && !hit_b && busy_q[rd_addr_b];

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: scoreboard bench for regfile_sb.
// Directed init/bypass/busy cases, then a randomised run against a model.
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] rd_addr_a = '0;
  logic [AW-1:0] rd_addr_b = '0;
  logic [DW-1:0] rd_data_a, rd_data_b;
  logic          rd_busy_a, rd_busy_b;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rsv_en = 1'b0;
  logic [AW-1:0] rsv_addr = '0;
  logic          ready;

  always #5 clk = ~clk;

  regfile_sb #(
    .DATA_W(DW),
    .ADDR_W(AW),
    .INIT_MODE(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rd_addr_a(rd_addr_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a),
    .rd_data_b(rd_data_b),
    .rd_busy_a(rd_busy_a),
    .rd_busy_b(rd_busy_b),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rsv_en(rsv_en),
    .rsv_addr(rsv_addr),
    .ready(ready)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sbq[$];

  logic [DW-1:0] m_mem [DEPTH];
  logic          m_bsy [DEPTH];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    sbq.push_back(e);
  endtask

  task automatic pop(input logic [31:0] got);
    exp_t e;
    if (sbq.size() == 0) begin
      chk("sbq_underflow", 32'(sbq.size()), 32'd1);
    end else begin
      e = sbq.pop_front();
      chk(e.tag, got, e.v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0;
    rsv_en = 1'b0;
  endtask

  // Call right after the rst-high edge; counts edges until ready.
  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    push(tag, 32'd32);
    while (!ready && n < 100) begin
      step();
      n++;
    end
    idle();
    pop(32'(n));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [AW-1:0] a, b;
    // init after a 1-cycle reset
    step();
    do_reset();
    push("rst_ready", 32'd0);
    #1 pop(32'(ready));
    rd_addr_a = 5'd17;
    push("init_rd17_zero", 32'd0);
    #1 pop(rd_data_a);
    wait_ready("init_cycles");
    rd_addr_a = 5'd17;
    rd_addr_b = 5'd0;
    push("reg17", 32'd17);
    push("reg0", 32'd0);
    #1;
    pop(rd_data_a);
    pop(rd_data_b);

    // reset mid-init, with blocked writes/reserves
    do_reset();
    repeat (10) step();
    rst = 1'b1;
    step();
    push("midinit_ready", 32'd0);
    pop(32'(ready));
    rst = 1'b0;
    wr_en = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'h0000_FFFF;
    rsv_en = 1'b1;
    rsv_addr = 5'd12;
    rd_addr_b = 5'd7;
    push("init_busy_b", 32'd0);
    push("init_data_b", 32'd0);
    #1;
    pop(32'(rd_busy_b));
    pop(rd_data_b);
    wait_ready("midinit_cycles");
    rd_addr_a = 5'd7;
    rd_addr_b = 5'd12;
    push("blk_reg7", 32'd7);
    push("blk_busy12", 32'd0);
    push("blk_reg12", 32'd12);
    #1;
    pop(rd_data_a);
    pop(32'(rd_busy_b));
    pop(rd_data_b);

    // bypass and register 0
    wr_en = 1'b1;
    wr_addr = 5'd5;
    wr_data = 32'hDEAD_BEEF;
    rd_addr_a = 5'd5;
    push("bypass5", 32'hDEAD_BEEF);
    #1 pop(rd_data_a);
    step();
    idle();
    push("stored5", 32'hDEAD_BEEF);
    #1 pop(rd_data_a);
    wr_en = 1'b1;
    wr_addr = 5'd0;
    wr_data = 32'hAAAA_5555;
    rsv_en = 1'b1;
    rsv_addr = 5'd0;
    rd_addr_a = 5'd0;
    push("r0_bypass", 32'd0);
    #1 pop(rd_data_a);
    step();
    idle();
    push("r0_after", 32'd0);
    push("r0_busy", 32'd0);
    #1;
    pop(rd_data_a);
    pop(32'(rd_busy_a));

    // reserve then writeback
    rsv_en = 1'b1;
    rsv_addr = 5'd8;
    rd_addr_a = 5'd8;
    push("rsv8_same", 32'd0);
    #1 pop(32'(rd_busy_a));
    step();
    idle();
    push("rsv8_next", 32'd1);
    #1 pop(32'(rd_busy_a));
    step();
    wr_en = 1'b1;
    wr_addr = 5'd8;
    wr_data = 32'h0000_1234;
    push("wb8_busy", 32'd0);
    push("wb8_data", 32'h0000_1234);
    #1;
    pop(32'(rd_busy_a));
    pop(rd_data_a);
    step();
    idle();
    push("wb8_busy_after", 32'd0);
    #1 pop(32'(rd_busy_a));

    // same-address reserve + write
    rsv_en = 1'b1;
    rsv_addr = 5'd9;
    wr_en = 1'b1;
    wr_addr = 5'd9;
    wr_data = 32'h0000_0099;
    rd_addr_a = 5'd9;
    rd_addr_b = 5'd9;
    step();
    idle();
    push("rw9_data", 32'h0000_0099);
    push("rw9_busy", 32'd1);
    push("rw9_data_b", 32'h0000_0099);
    push("rw9_busy_b", 32'd1);
    #1;
    pop(rd_data_a);
    pop(32'(rd_busy_a));
    pop(rd_data_b);
    pop(32'(rd_busy_b));

    // different-address reserve + write
    rsv_en = 1'b1;
    rsv_addr = 5'd3;
    wr_en = 1'b1;
    wr_addr = 5'd4;
    wr_data = 32'h0000_0044;
    step();
    idle();
    rd_addr_a = 5'd3;
    rd_addr_b = 5'd4;
    push("busy3", 32'd1);
    push("busy4", 32'd0);
    push("data4", 32'h0000_0044);
    #1;
    pop(32'(rd_busy_a));
    pop(32'(rd_busy_b));
    pop(rd_data_b);

    // reset from RUN drops reservations and restores contents
    do_reset();
    wait_ready("rerun_cycles");
    rd_addr_a = 5'd9;
    rd_addr_b = 5'd5;
    push("rerun_busy9", 32'd0);
    push("rerun_reg5", 32'd5);
    #1;
    pop(32'(rd_busy_a));
    pop(rd_data_b);

    // randomised run against a reference model
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i] = DW'(i);
      m_bsy[i] = 1'b0;
    end
    for (int c = 0; c < 300; c++) begin
      step();
      wr_en = 1'($urandom_range(0, 1));
      wr_addr = AW'($urandom_range(0, 7));
      wr_data = $urandom;
      rsv_en = 1'($urandom_range(0, 1));
      rsv_addr = AW'($urandom_range(0, 7));
      a = AW'($urandom_range(0, 7));
      b = (c % 4 == 0) ? a : AW'($urandom_range(0, 7));
      rd_addr_a = a;
      rd_addr_b = b;
      push("rnd_data_a", (a == 0) ? 32'd0 :
           (wr_en && wr_addr == a) ? wr_data : m_mem[a]);
      push("rnd_busy_a", 32'(a != 0 && !(wr_en && wr_addr == a) && m_bsy[a]));
      push("rnd_data_b", (b == 0) ? 32'd0 :
           (wr_en && wr_addr == b) ? wr_data : m_mem[b]);
      push("rnd_busy_b", 32'(b != 0 && !(wr_en && wr_addr == b) && m_bsy[b]));
      #1;
      pop(rd_data_a);
      pop(32'(rd_busy_a));
      pop(rd_data_b);
      pop(32'(rd_busy_b));
      if (wr_en && wr_addr != 0) m_mem[wr_addr] = wr_data;
      if (wr_en) m_bsy[wr_addr] = 1'b0;
      if (rsv_en && rsv_addr != 0) m_bsy[rsv_addr] = 1'b1;
    end
    step();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
